// File: rtl/stack_machine_stack.sv
`default_nettype none
// ============================================================================
// Module   : stack_machine_stack
// Purpose  : Operand stack for the function-plotter stack machine. The top two
//            entries (tos/nos) live in registers so a binary operation can
//            read both operands combinationally. Deeper entries live in a
//            single-write, registered-read memory of DEPTH-2 words. Shrinking
//            ops that expose a memory-resident entry spend one extra cycle
//            (REFILL) moving that entry into nos.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            clear_i           - synchronous flush, highest priority
//            op_valid_i/op_i   - operation request (NOP/PUSH/POP/REPLACE2)
//            op_data_i         - value for PUSH and REPLACE2
//            op_ready_o        - operation can be accepted this cycle
//            tos_o/nos_o       - registered top / next-of-stack
//            count_o           - number of entries
//            empty_o/full_o    - decoded from count
//            overflow_o/underflow_o - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module stack_machine_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  op_valid_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] op_data_i,
    output logic                  op_ready_o,
    output logic [DATA_WIDTH-1:0] tos_o,
    output logic [DATA_WIDTH-1:0] nos_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int MEM_DEPTH = DEPTH - 2;
    // A one-word memory still needs a one-bit address.
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REP2 = 2'b11;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0]   tos_q, tos_d;
    logic [DATA_WIDTH-1:0]   nos_q, nos_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    mem_we;
    logic                    mem_re;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;
    logic                    is_empty;
    logic                    is_full;
    logic                    ge2;
    logic                    ge3;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_WIDTH'(DEPTH));
    assign ge2      = (count_q >= CNT_WIDTH'(2));
    assign ge3      = (count_q >= CNT_WIDTH'(3));

    // On PUSH the old nos spills to slot count-2; on a shrink the entry that
    // becomes the new nos sits at slot count-3 (both relative to old count).
    assign wr_addr  = AW'(count_q - CNT_WIDTH'(2));
    assign rd_addr  = AW'(count_q - CNT_WIDTH'(3));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;

        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = ACCEPT;
        end else if (state_q == REFILL) begin
            nos_d   = rdata_q;
            state_d = ACCEPT;
        end else if (op_valid_i) begin
            case (op_i)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = ge2;
                        nos_d   = tos_q;
                        tos_d   = op_data_i;
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = nos_q;
                        count_d = count_q - CNT_WIDTH'(1);
                        if (ge3) begin
                            mem_re  = 1'b1;
                            state_d = REFILL;
                        end
                    end
                end
                OP_REP2: begin
                    if (!ge2) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = op_data_i;
                        count_d = count_q - CNT_WIDTH'(1);
                        if (ge3) begin
                            mem_re  = 1'b1;
                            state_d = REFILL;
                        end
                    end
                end
                OP_NOP:  ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array: no reset, one write port, one registered read port.
    // PUSH writes and shrink reads are never accepted on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= nos_q;
        end
        if (mem_re) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    assign op_ready_o  = (state_q == ACCEPT);
    assign tos_o       = tos_q;
    assign nos_o       = nos_q;
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule
`default_nettype wire

// File: doc/stack_machine_stack.md
# stack_machine_stack

Hardware operand stack for the function-plotter stack machine, replacing the bare dual-port memory plus external pointer logic. The top two entries are held in registers, so the evaluator can read both operands of a binary operation combinationally. The rest of the stack is kept in a single-write, synchronous-read memory of `DEPTH-2` entries. The block handles the push, pop and binary-replace pointer bookkeeping, the one-cycle refill after a shrink, and sticky overflow/underflow detection.

## Interface
- `DATA_WIDTH`, 16: entry width in bits.
- `DEPTH`, 64: maximum number of entries, minimum 3. `CNT_WIDTH = $clog2(DEPTH+1)` (localparam).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous stack flush; highest priority.
- `op_valid`  in  1  operation request.
- `op`  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE2 (pop two, push `op_data`).
- `op_data`  in  DATA_WIDTH  value for PUSH and REPLACE2.
- `op_ready`  out  1  block can accept an operation this cycle.
- `tos`  out  DATA_WIDTH  top of stack (entry `count-1`); registered.
- `nos`  out  DATA_WIDTH  next of stack (entry `count-2`); registered.
- `count`  out  CNT_WIDTH  current number of entries.
- `empty`  out  1  `count==0`, combinational from `count`.
- `full`  out  1  `count==DEPTH`, combinational from `count`.
- `overflow`  out  1  sticky: PUSH attempted while full.
- `underflow`  out  1  sticky: POP attempted on empty, or REPLACE2 attempted with `count<2`.

## Operation
- **Storage:** entry i, for i < `count-2`, lives at memory address i. Memory has one write port and one registered read port.
- **States:** ACCEPT (`op_ready=1`) and REFILL (`op_ready=0`).
- **Acceptance:** an op is accepted on a rising edge with `op_valid && op_ready`. NOP changes nothing.
- **PUSH, not full:**
  - if `count>=2`, write `nos` to address `count-2`;
  - `nos<=tos`, `tos<=op_data`, `count+1`;
  - stay in ACCEPT.
- **PUSH, full:** `overflow<=1`; stack unchanged.
- **POP, count>=1:**
  - `tos<=nos`, `count-1`;
  - if the new count is 2 or more, issue a read at address `count-3` and go to REFILL;
  - otherwise `nos` is left unchanged (don't-care).
- **POP, empty:** `underflow<=1`; stack unchanged.
- **REPLACE2, count>=2:**
  - `tos<=op_data`, `count-1`;
  - if `count>=3`, issue a read at address `count-3` and go to REFILL.
- **REPLACE2, count<2:** `underflow<=1`; stack unchanged.
- **REFILL:** `nos<=` memory read data, then return to ACCEPT. `op_valid` is ignored in this state.
- **Error ops** are still consumed; they never alter `count`, `tos`, `nos` or memory.
- **clear:** `count<=0`, flags cleared, state forced to ACCEPT. It overrides any concurrent op and any pending REFILL. Memory contents are not touched.
- **Count arithmetic:** unsigned; never wraps, because every over/underflow case is blocked.

## Timing
- **Reset (async, rst_n=0):**
  - `count=0`, `tos=0`, `nos=0`;
  - `overflow=0`, `underflow=0`;
  - state ACCEPT, so `op_ready=1`, `empty=1`, `full=0`.
- **Output update:** `tos`, `count` and the flags update on the accepting edge.
- **nos timing:**
  - after PUSH, `nos` updates on the same edge;
  - after a shrinking op that needs a refill, `nos` is stale for one cycle and valid after the REFILL edge.
- **Throughput:** 1 op/cycle for PUSH/NOP. POP/REPLACE2 with refill cost 2 cycles.
- **Memory write in PUSH:** occurs on the accepting edge. A following POP's refill read of the same address returns the newly written value. Write and read never fall in the same cycle.
- **Reset deassertion mid-REFILL:** state restarts in ACCEPT and no refill completes.
- **Flag clearing:** only by `clear` or reset.

## Test plan
- Reset, then PUSH 1, 2, 3 on consecutive cycles -> `count=3`, `tos=3`, `nos=2`, `op_ready` high throughout.
- From [1,2,3], REPLACE2 `op_data=5` -> next cycle `tos=5`, `count=2`, `op_ready=0`; following cycle `nos=1`, `op_ready=1`.
- With `DEPTH=4`: push 4 values, then PUSH 9 -> `overflow=1`, `full=1`, `tos` unchanged. `clear` -> `count=0`, `overflow=0`, `empty=1`.
- On empty: POP -> `underflow=1`, `count=0`. After clear, PUSH 7 then REPLACE2 -> `underflow=1`, `tos=7`, `count=1`.
- Push 10..19 (10 entries), then POP ×8 -> sequence of `tos` 18..11, each POP followed by one `op_ready=0` cycle; final `count=2`, `nos=10`.
- Assert `rst_n=0` during REFILL -> all outputs at reset values immediately; `op_ready=1` after release.
